// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dmem_pkg
// Brief   : Shared state encoding and default sizing for the dmem responder.
// Revision: 1.0
// ============================================================================
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEFAULT_DEPTH = 64;
    localparam int DEFAULT_WAIT  = 2;

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// ============================================================================
// Module  : dmem_array
// Brief   : DEPTH x 32 word store, byte-enabled synchronous write, async read.
// Revision: 1.0
// ============================================================================
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    // Deliberately not reset: contents survive a responder reset.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int n = 0; n < 4; n++) begin
                if (be[n]) begin
                    mem[addr][8*n +: 8] <= wdata[8*n +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_resp.sv
`default_nettype none
// ============================================================================
// Module  : dmem_resp
// Brief   : Valid/ready data-memory responder with fixed access latency.
// Revision: 1.0
// ============================================================================
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int WAIT  = DEFAULT_WAIT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    state_t      state;
    state_t      state_d;
    logic [3:0]  cnt;
    logic [3:0]  cnt_d;
    logic        access;
    logic        accept;

    logic        lat_we;
    logic        lat_byte;
    logic [31:0] lat_addr;
    logic [31:0] lat_wdata;

    logic        acc_we;
    logic        acc_byte;
    logic [31:0] acc_addr;
    logic [31:0] acc_wdata;

    logic [29:0] idx;
    logic [1:0]  lane;
    logic        in_range;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic [31:0] rd_word;
    logic [31:0] rd_value;

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign accept    = req_valid & req_ready;

    // With WAIT = 0 the access happens on the accept edge, before the
    // request has been latched, so the live inputs feed the datapath.
    assign acc_we    = (state == IDLE) ? req_we    : lat_we;
    assign acc_byte  = (state == IDLE) ? req_byte  : lat_byte;
    assign acc_addr  = (state == IDLE) ? req_addr  : lat_addr;
    assign acc_wdata = (state == IDLE) ? req_wdata : lat_wdata;

    assign idx      = acc_addr[31:2];
    assign lane     = acc_addr[1:0];
    assign in_range = (idx < 30'(DEPTH));

    always_comb begin
        wr_be    = acc_byte ? (4'b0001 << lane) : 4'b1111;
        wr_data  = acc_byte ? {4{acc_wdata[7:0]}} : acc_wdata;
        rd_value = acc_byte ? {24'b0, rd_word[{lane, 3'b000} +: 8]} : rd_word;
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk   (clk),
        .we    (access & acc_we & in_range),
        .be    (wr_be),
        .addr  (idx[AW-1:0]),
        .wdata (wr_data),
        .rdata (rd_word)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // The access edge is the one on which the counter reaches zero, which
    // gives WAIT+1 cycles of latency and WAIT+2 cycles of request spacing.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        access  = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    cnt_d = WAIT_CNT;
                    if (WAIT_CNT == 4'd0) begin
                        access  = 1'b1;
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    access  = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lat_we    <= 1'b0;
            lat_byte  <= 1'b0;
            lat_addr  <= 32'd0;
            lat_wdata <= 32'd0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                lat_we    <= req_we;
                lat_byte  <= req_byte;
                lat_addr  <= req_addr;
                lat_wdata <= req_wdata;
            end
            if (access) begin
                rsp_err   <= ~in_range;
                rsp_rdata <= (in_range && !acc_we) ? rd_value : 32'd0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_resp.sv
`default_nettype none
// ============================================================================
// Module  : tb_dmem_resp
// Brief   : Self-checking bench: transaction-level model plus directed vectors.
// Revision: 1.0
// ============================================================================
module tb_dmem_resp;

    localparam int W = 2;
    localparam int D = 64;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we    = 1'b0;
    logic        req_byte  = 1'b0;
    logic [31:0] req_addr  = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_ready = 1'b0;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    logic        b_req_valid = 1'b0;
    logic        b_req_we    = 1'b0;
    logic        b_req_byte  = 1'b0;
    logic [31:0] b_req_addr  = 32'd0;
    logic [31:0] b_req_wdata = 32'd0;
    logic        b_rsp_ready = 1'b0;
    logic        b_req_ready;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_rdata;
    logic        b_rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_resp #(.DEPTH(D), .WAIT(W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dmem_resp #(.DEPTH(D), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
        .req_byte(b_req_byte), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
        .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one outstanding request, response visible from
    // cycle W+1 after acceptance until handshake; stores land at that point.
    bit          m_busy  = 1'b0;
    int          m_age   = 0;
    bit          m_err   = 1'b0;
    bit          m_dchk  = 1'b0;
    bit          m_pend  = 1'b0;
    bit          m_byte  = 1'b0;
    logic [31:0] m_data  = 32'd0;
    logic [31:0] m_wd    = 32'd0;
    int          m_idx   = 0;
    int          m_lane  = 0;
    logic [31:0] m_mem   [D];
    bit          m_known [D];
    bit          vis;

    task automatic m_commit();
        if (m_pend) begin
            if (m_byte) begin
                m_mem[m_idx][8*m_lane +: 8] = m_wd[7:0];
            end else begin
                m_mem[m_idx]   = m_wd;
                m_known[m_idx] = 1'b1;
            end
            m_pend = 1'b0;
        end
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_busy = 1'b0;
            m_pend = 1'b0;
        end else if (m_busy) begin
            if (m_age >= W + 1) begin
                if (rsp_ready) m_busy = 1'b0;
            end else begin
                m_age++;
                if (m_age == W + 1) m_commit();
            end
        end else if (req_valid) begin
            m_busy = 1'b1;
            m_age  = 1;
            m_err  = 1'b0;
            m_data = 32'd0;
            m_dchk = 1'b1;
            m_pend = 1'b0;
            if (req_addr[31:2] >= 30'(D)) begin
                m_err = 1'b1;
            end else begin
                m_idx  = int'(req_addr[31:2]);
                m_lane = int'(req_addr[1:0]);
                if (req_we) begin
                    m_pend = 1'b1;
                    m_byte = req_byte;
                    m_wd   = req_wdata;
                end else if (!m_known[m_idx]) begin
                    m_dchk = 1'b0;
                end else if (req_byte) begin
                    m_data = (m_mem[m_idx] >> (8 * m_lane)) & 32'hFF;
                end else begin
                    m_data = m_mem[m_idx];
                end
            end
            if (m_age == W + 1) m_commit();
        end
    end

    always @(negedge clk) begin
        vis = m_busy && (m_age >= W + 1);
        chk("model_rsp_valid", rsp_valid, vis);
        chk("model_req_ready", req_ready, !m_busy);
        if (vis) begin
            chk("model_rsp_err", rsp_err, m_err);
            if (m_dchk) chk("model_rsp_rdata", rsp_rdata, m_data);
        end
    end

    task automatic xact(input logic we, input logic bt, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold, input bit junk,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_byte = bt;
        req_addr = addr; req_wdata = wd; rsp_ready = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clk); n++; end
        if (n == 50) chk("accept_timeout", req_ready, 1);
        @(posedge clk);
        @(negedge clk);
        if (junk) begin
            req_we = 1'b1; req_byte = 1'b0; req_addr = 32'h10; req_wdata = 32'hFFFF_FFFF;
        end else begin
            req_valid = 1'b0;
        end
        lat = 1;
        while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
        rd = rsp_rdata;
        e  = rsp_err;
        repeat (hold) begin
            @(negedge clk);
            chk("backpressure_req_ready", req_ready, 0);
            chk("backpressure_rsp_valid", rsp_valid, 1);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic run(input string nm, input logic we, input logic bt,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input int hold, input bit junk,
                       input logic [31:0] exp_rd, input logic exp_err);
        logic [31:0] rd;
        logic        e;
        int          lat;
        xact(we, bt, addr, wd, hold, junk, rd, e, lat);
        chk({nm, "_latency"}, lat, W + 1);
        chk({nm, "_rdata"}, rd, exp_rd);
        chk({nm, "_err"}, e, exp_err);
    endtask

    // WAIT = 0 instance: accept timestamps for spacing checks.
    int cyc = 0;
    int b_n = 0;
    int b_acc [8];

    always @(posedge clk) begin
        cyc++;
        if (b_req_valid && b_req_ready) begin
            if (b_n < 8) b_acc[b_n] = cyc;
            b_n++;
        end
    end

    logic [31:0] b_addr [5];
    logic [31:0] b_wd   [5];
    logic [31:0] b_exp  [5];
    logic        b_we   [5];
    logic        b_bt   [5];

    task automatic b_apply(input int i);
        b_req_we = b_we[i]; b_req_byte = b_bt[i];
        b_req_addr = b_addr[i]; b_req_wdata = b_wd[i];
    endtask

    initial begin
        int t;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("reset_req_ready", req_ready, 1);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_rdata", rsp_rdata, 0);
        chk("reset_rsp_err", rsp_err, 0);

        run("st_word_10",  1, 0, 32'h10, 32'h1234_5678, 0, 0, 32'h0, 0);
        run("ld_word_10",  0, 0, 32'h10, 32'h0,         0, 0, 32'h1234_5678, 0);
        run("st_byte_11",  1, 1, 32'h11, 32'hFFFF_FFAB, 0, 0, 32'h0, 0);
        run("ld_word_10b", 0, 0, 32'h10, 32'h0,         0, 0, 32'h1234_AB78, 0);
        run("ld_byte_11",  0, 1, 32'h11, 32'h0,         0, 0, 32'h0000_00AB, 0);
        run("ld_byte_13",  0, 1, 32'h13, 32'h0,         0, 0, 32'h0000_0012, 0);
        run("ld_word_13",  0, 0, 32'h13, 32'h0,         0, 0, 32'h1234_AB78, 0);
        run("st_word_00",  1, 0, 32'h00, 32'hCAFE_F00D, 0, 0, 32'h0, 0);
        run("st_word_20",  1, 0, 32'h20, 32'h1111_1111, 0, 0, 32'h0, 0);

        run("ld_oor_100",  0, 0, 32'h100,       32'h0,         0, 0, 32'h0, 1);
        run("st_oor_100",  1, 0, 32'h100,       32'hBAD0_BAD0, 0, 0, 32'h0, 1);
        run("st_oor_top",  1, 1, 32'hFFFF_FFFC, 32'h0000_00EE, 0, 0, 32'h0, 1);
        run("ld_after_oor_00", 0, 0, 32'h00, 32'h0, 0, 0, 32'hCAFE_F00D, 0);
        run("ld_after_oor_10", 0, 0, 32'h10, 32'h0, 0, 0, 32'h1234_AB78, 0);

        run("backpressure_ld_10", 0, 0, 32'h10, 32'h0, 5, 1, 32'h1234_AB78, 0);
        #1;
        chk("after_handshake_idle", req_ready, 1);
        run("ld_after_junk_10", 0, 0, 32'h10, 32'h0, 0, 0, 32'h1234_AB78, 0);

        run("ld_word_20", 0, 0, 32'h20, 32'h0, 0, 0, 32'h1111_1111, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("busy_before_reset", req_ready, 0);
        #2 reset = 1'b1;
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_rsp_rdata", rsp_rdata, 0);
        chk("abort_rsp_err", rsp_err, 0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_req_ready", req_ready, 1);
        run("ld_after_abort_20", 0, 0, 32'h20, 32'h0, 0, 0, 32'h1111_1111, 0);

        b_we[0] = 1; b_bt[0] = 0; b_addr[0] = 32'h8; b_wd[0] = 32'h0000_0055; b_exp[0] = 32'h0;
        b_we[1] = 0; b_bt[1] = 0; b_addr[1] = 32'h8; b_wd[1] = 32'h0;         b_exp[1] = 32'h0000_0055;
        b_we[2] = 1; b_bt[2] = 1; b_addr[2] = 32'h9; b_wd[2] = 32'h0000_0077; b_exp[2] = 32'h0;
        b_we[3] = 0; b_bt[3] = 0; b_addr[3] = 32'h8; b_wd[3] = 32'h0;         b_exp[3] = 32'h0000_7755;
        b_we[4] = 0; b_bt[4] = 1; b_addr[4] = 32'h9; b_wd[4] = 32'h0;         b_exp[4] = 32'h0000_0077;
        @(negedge clk);
        b_rsp_ready = 1'b1;
        b_req_valid = 1'b1;
        b_apply(0);
        for (int i = 0; i < 5; i++) begin
            t = 0;
            while (b_n <= i && t < 20) begin @(negedge clk); t++; end
            chk("w0_rsp_valid", b_rsp_valid, 1);
            chk("w0_rsp_rdata", b_rsp_rdata, b_exp[i]);
            chk("w0_rsp_err", b_rsp_err, 0);
            if (i < 4) b_apply(i + 1);
            else       b_req_valid = 1'b0;
            @(negedge clk);
            chk("w0_rsp_one_cycle", b_rsp_valid, 0);
        end
        for (int i = 0; i < 4; i++) begin
            chk("w0_accept_spacing", b_acc[i+1] - b_acc[i], 2);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by %0t, expected end of stimulus", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
